// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor.
//
// A WIDTH-bit add (or subtract) is split into NSTAGE = WIDTH/SEG ripple
// segments. Stage 0 registers the operands; each following register level
// resolves one more SEG-bit segment. The output register receives the
// completed result, so a result appears NSTAGE cycles after its accepting
// edge. The whole pipe, bubbles included, stalls when the output is held
// and downstream is not ready.
//
// Parameters:
//   WIDTH  operand/result width (must be a multiple of SEG)
//   SEG    bits resolved per pipeline stage
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set this cycle
//   xin, yin   operands X and Y
//   zin        carry-in (add mode only)
//   sub        0: X+Y+zin, 1: X-Y
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sout       sum/difference
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//
// Optional feature macro: ADD_PIPE_SATURATE_EN
//   When defined, an overflowing result is clamped to the signed extreme
//   matching the sign of X. When undefined, sout wraps modulo 2^WIDTH.

module add_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    input  logic             zin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = int'(WIDTH / SEG);

    if ((WIDTH % SEG) != 0) begin : gen_width_check
        $error("add_pipe: WIDTH must be a multiple of SEG");
    end

    // Stage k holds the operands, the carry into segment k, and the result
    // bits below segment k that earlier stages have already resolved.
    logic             valid_q [NSTAGE];
    logic [WIDTH-1:0] a_q     [NSTAGE];
    logic [WIDTH-1:0] b_q     [NSTAGE];
    logic             carry_q [NSTAGE];
    logic [WIDTH-1:0] sum_q   [NSTAGE];

    logic             out_valid_q;
    logic [WIDTH-1:0] sout_q;
    logic             cout_q;
    logic             ovf_q;

    logic [SEG:0]     seg_sum [NSTAGE];
    logic [WIDTH-1:0] sum_ext [NSTAGE];

    logic             advance;
    logic [WIDTH-1:0] res_sum;
    logic [WIDTH-1:0] res_sout;
    logic             res_cout;
    logic             res_ovf;
    logic             a_msb;
    logic             b_msb;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign sout      = sout_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Per-stage segment adder and partial-result merge.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            seg_sum[k] = {1'b0, a_q[k][k*SEG +: SEG]}
                       + {1'b0, b_q[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, carry_q[k]};
            sum_ext[k] = sum_q[k];
            sum_ext[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
    end

    // Flags from the last segment. The carry into the MSB is recovered from
    // the MSB sum bit: s = a ^ b ^ c_in.
    always_comb begin
        res_sum  = sum_ext[NSTAGE-1];
        res_cout = seg_sum[NSTAGE-1][SEG];
        a_msb    = a_q[NSTAGE-1][WIDTH-1];
        b_msb    = b_q[NSTAGE-1][WIDTH-1];
        res_ovf  = (a_msb ^ b_msb ^ res_sum[WIDTH-1]) ^ res_cout;
`ifdef ADD_PIPE_SATURATE_EN
        if (res_ovf) begin
            res_sout = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_sout = res_sum;
        end
`else
        res_sout = res_sum;
`endif
    end

    // Control: valid bits and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sout_q      <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < NSTAGE; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            out_valid_q <= valid_q[NSTAGE-1];
            // Output data only changes when a real result shifts in.
            if (valid_q[NSTAGE-1]) begin
                sout_q <= res_sout;
                cout_q <= res_cout;
                ovf_q  <= res_ovf;
            end
        end
    end

    // Datapath: only loaded alongside a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            if (in_valid) begin
                a_q[0]     <= xin;
                b_q[0]     <= sub ? ~yin : yin;
                carry_q[0] <= sub ? 1'b1 : zin;
                sum_q[0]   <= '0;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                if (valid_q[k-1]) begin
                    a_q[k]     <= a_q[k-1];
                    b_q[k]     <= b_q[k-1];
                    carry_q[k] <= seg_sum[k-1][SEG];
                    sum_q[k]   <= sum_ext[k-1];
                end
            end
        end
    end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor built from chained full-adder segments.
- Splits a WIDTH-bit operation into WIDTH/SEG ripple segments, with one register stage per segment.
- Provides valid/ready handshakes on both sides so it can be dropped into datapaths that stall.
- Adds features a single-bit full adder lacks: width generality, subtract mode, carry/overflow flags, throughput of one op per cycle, and backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage. NSTAGE = WIDTH/SEG.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- xin  input  WIDTH  operand X.
- yin  input  WIDTH  operand Y.
- zin  input  1  carry-in; used in add mode only.
- sub  input  1  0 = X+Y+zin; 1 = X-Y (computed as X+~Y+1, zin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sout  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: every stage valid bit cleared. out_valid=0, sout=0, cout=0, ovf=0, in_ready=1. Reset takes effect on the clock edge where rst=1, including mid-operation; all in-flight ops are discarded.
- Accept: when in_valid && in_ready, stage 0 captures X, Y' (Y, or ~Y if sub), and carry (zin, or 1 if sub), and computes bits [SEG-1:0].
- Stage k (k≥1):
  - Adds bits [k*SEG +: SEG] using the registered carry from stage k-1.
  - Upper operand bits and lower result bits are skew-registered forward unchanged.
  - The last stage also produces cout and ovf.
- Latency: out_valid rises NSTAGE cycles after the accepting edge. Default: 4 cycles.
- Throughput: one op per cycle when unstalled.
- Stall rule:
  - advance = !out_valid || out_ready.
  - When advance=0, all stages hold, including bubbles.
  - in_ready = advance, combinationally.
- Output hold: while out_valid && !out_ready, sout/cout/ovf/out_valid are stable.
- Ordering: results leave in acceptance order; no op is dropped or duplicated.
- Bubbles: a cycle with no accept inserts a valid=0 slot that propagates normally.
- Simultaneous out handshake and new accept in the same cycle is legal; the pipe shifts by one.
- Output registers are updated only when a valid result shifts in. Otherwise they hold their last value.
- WIDTH % SEG != 0 is a compile-time error via a generate-time check.

Optional Feature:
- Macro: ADD_PIPE_SATURATE_EN.
- Defined:
  - When ovf=1, sout is clamped to the signed extreme: 0x7FF..F if X is non-negative, otherwise 0x800..0.
  - ovf still reports the overflow.
  - Clamping happens in the last stage, so latency is unchanged.
- Not defined: sout is the wrapped modulo-2^WIDTH result. No saturation logic is present.

Test Plan (WIDTH=16, SEG=4):
- Add 0xFFFF+0x0001, zin=0, sub=0, out_ready=1 → 4 cycles later: sout=0x0000, cout=1, ovf=0, out_valid pulse of one cycle.
- Add 0x7FFF+0x0001 → sout=0x8000, cout=0, ovf=1. With ADD_PIPE_SATURATE_EN: sout=0x7FFF, ovf=1.
- Subtract 0x0005-0x0007 (sub=1, zin=1 ignored) → sout=0xFFFE, cout=0, ovf=0. Subtract 0x8000-0x0001 → sout=0x7FFF, ovf=1 (saturate build: 0x8000).
- Stream ops A=1+1, B=2+2, C=3+3, D=4+4, E=5+5 back-to-back. Drop out_ready for 3 cycles once A appears:
  - in_ready=0 during the stall, and A held stable.
  - Results then arrive 2,4,6,8,10 in order with no loss.
- Accept 3 ops, then assert rst for one cycle two cycles later → out_valid=0 from the next edge. No stale result appears. First op after reset returns correctly at latency 4.
- Alternating in_valid 1/0 with out_ready=1 → out_valid alternates 1/0 with a 4-cycle offset; each result matches its operands.
